store_buffer: RTL and testbench

- Write-side counterpart of the data-memory load path: accepts sw/sh/sb store requests from the core, queues them in a small FIFO and drains them to DataMemory one word-aligned write at a time.
- Drains use a we/ack handshake with byte enables.
- Flags load hazards when a load targets a word with a pending store, so the core can stall.
- Sits between the Mips core (aluout/writedata/memwrite) and dmem.

---
 rtl/store_buffer.sv | 196 +++++++++++++++++++
 tb/tb_store_buffer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: queues sw/sh/sb stores with lane formatting and drains them to data memory in FIFO order.
// Revision 1.0
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic [1:0]               st_size,
  output logic                     st_err,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hazard,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wd,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WAW = AW - 2;

  typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wd_q, mem_wd_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              st_err_q, st_err_d;

  logic [WAW-1:0]    ent_addr_q [DEPTH];
  logic [WAW-1:0]    ent_addr_d [DEPTH];
  logic [DW-1:0]     ent_wd_q   [DEPTH];
  logic [DW-1:0]     ent_wd_d   [DEPTH];
  logic [3:0]        ent_be_q   [DEPTH];
  logic [3:0]        ent_be_d   [DEPTH];

  logic [3:0]        fmt_be;
  logic [DW-1:0]     fmt_wd;
  logic              fmt_bad;
  logic              accept, push, pop;
  logic              do_load;
  logic [PW-1:0]     load_idx;
  logic [PW-1:0]     nxt_ptr;
  logic [PW-1:0]     off;
  logic              hz;
  logic              unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr[1:0];

  // Lane positioning is done once at accept so the drain path is a plain copy.
  always_comb begin
    fmt_be  = 4'b0000;
    fmt_wd  = st_data;
    fmt_bad = 1'b0;
    case (st_size)
      2'd0: begin
        fmt_be = 4'b0001 << st_addr[1:0];
        fmt_wd = {4{st_data[7:0]}};
      end
      2'd1: begin
        fmt_bad = st_addr[0];
        fmt_be  = st_addr[1] ? 4'b1100 : 4'b0011;
        fmt_wd  = {2{st_data[15:0]}};
      end
      2'd2: begin
        fmt_bad = |st_addr[1:0];
        fmt_be  = 4'b1111;
      end
      default: fmt_bad = 1'b1;
    endcase
  end

  assign st_ready = !reset && (count_q < CW'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign push     = accept && !fmt_bad;
  assign pop      = (state_q == WRITE) && mem_ack;
  assign nxt_ptr  = rd_ptr_q + PW'(1);

  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_wd_d   = ent_wd_q;
    ent_be_d   = ent_be_q;
    wr_ptr_d   = wr_ptr_q;
    if (push) begin
      ent_addr_d[wr_ptr_q] = st_addr[AW-1:2];
      ent_wd_d[wr_ptr_q]   = fmt_wd;
      ent_be_d[wr_ptr_q]   = fmt_be;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    mem_we_d   = mem_we_q;
    do_load    = 1'b0;
    load_idx   = rd_ptr_q;
    st_err_d   = accept && fmt_bad;
    count_d    = count_q + CW'(push) - CW'(pop);
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          do_load  = 1'b1;
          mem_we_d = 1'b1;
          state_d  = WRITE;
        end
      end
      default: begin
        if (mem_ack) begin
          rd_ptr_d = nxt_ptr;
          if (count_q > CW'(1)) begin
            do_load  = 1'b1;
            load_idx = nxt_ptr;
          end else begin
            mem_we_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
    endcase
    mem_addr_d = do_load ? {ent_addr_q[load_idx], 2'b00} : mem_addr_q;
    mem_wd_d   = do_load ? ent_wd_q[load_idx] : mem_wd_q;
    mem_be_d   = do_load ? ent_be_q[load_idx] : mem_be_q;
  end

  // Slot i is live when its distance from the head is below the occupancy.
  always_comb begin
    hz  = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (ent_addr_q[i] == ld_addr[AW-1:2])) begin
        hz = 1'b1;
      end
    end
  end

  assign ld_hazard = ld_valid && hz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_be_q   <= '0;
      st_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      mem_be_q   <= mem_be_d;
      st_err_q   <= st_err_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_wd_q   <= ent_wd_d;
    ent_be_q   <= ent_be_d;
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;
  assign mem_be   = mem_be_q;
  assign st_err   = st_err_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vector table, hand sequences and randomized traffic against a queue-based model.
`default_nettype none

module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = 2'd2;
  logic        st_err;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_hazard;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b1;
  logic [2:0]  count;
  logic        empty;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .st_err(st_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_be(mem_be),
    .mem_ack(mem_ack), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: list of pending stores plus whether the head is on the bus.
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } ent_t;

  ent_t q[$];
  bit   busy  = 1'b0;
  bit   err_m = 1'b0;

  function automatic bit is_bad(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic ent_t make_ent(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    ent_t e;
    e.addr = {a[31:2], 2'b00};
    case (sz)
      2'd0:    begin e.be = 4'(1 << a[1:0]); e.wd = {d[7:0], d[7:0], d[7:0], d[7:0]}; end
      2'd1:    begin e.be = a[1] ? 4'hC : 4'h3; e.wd = {d[15:0], d[15:0]}; end
      default: begin e.be = 4'hF; e.wd = d; end
    endcase
    return e;
  endfunction

  task automatic model_clear();
    q.delete();
    busy  = 1'b0;
    err_m = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    bit bad;
    if (reset) begin
      model_clear();
    end else begin
      acc = st_valid && (q.size() < DEPTH);
      bad = is_bad(st_addr, st_size);
      if (busy) begin
        if (mem_ack) begin
          void'(q.pop_front());
          busy = (q.size() > 0);
        end
      end else begin
        busy = (q.size() > 0);
      end
      err_m = acc && bad;
      if (acc && !bad) q.push_back(make_ent(st_addr, st_data, st_size));
    end
  endtask

  task automatic check_model();
    bit hz;
    hz = 1'b0;
    foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) hz = 1'b1;
    check("m_we", mem_we, busy);
    if (busy && q.size() > 0) begin
      check("m_addr", mem_addr, q[0].addr);
      check("m_be", mem_be, q[0].be);
      check("m_wd", mem_wd, q[0].wd);
    end
    check("m_count", count, q.size());
    check("m_empty", empty, q.size() == 0);
    check("m_ready", st_ready, !reset && q.size() < DEPTH);
    check("m_err", st_err, err_m);
    check("m_hazard", ld_hazard, ld_valid && hz);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_st(input bit v, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    st_valid = v;
    st_addr  = a;
    st_size  = sz;
    st_data  = d;
  endtask

  typedef struct {
    bit          sv;
    logic [31:0] sa;
    logic [1:0]  ss;
    logic [31:0] sd;
    bit          ack;
    bit          lv;
    logic [31:0] la;
    bit          we;
    logic [31:0] ma;
    logic [3:0]  be;
    logic [31:0] wd;
    int          cnt;
    bit          err;
    bit          hz;
  } vec_t;

  vec_t        tbl[14];
  logic [31:0] addrs[5];
  logic [31:0] seen[$];
  int          idx;
  bit          rdy;

  initial begin
    tbl[0]  = '{1, 32'd12,   2'd2, 32'd999,    1, 0, 32'h0,  0, 32'h0,  4'h0, 32'h0,        1, 0, 0};
    tbl[1]  = '{0, 32'd0,    2'd2, 32'd0,      1, 0, 32'h0,  1, 32'd12, 4'hF, 32'd999,      1, 0, 0};
    tbl[2]  = '{0, 32'd0,    2'd2, 32'd0,      1, 0, 32'h0,  0, 32'h0,  4'h0, 32'h0,        0, 0, 0};
    tbl[3]  = '{1, 32'h0D,   2'd0, 32'hAB,     1, 0, 32'h0,  0, 32'h0,  4'h0, 32'h0,        1, 0, 0};
    tbl[4]  = '{1, 32'h12,   2'd1, 32'h1234,   1, 0, 32'h0,  1, 32'h0C, 4'h2, 32'hABABABAB, 2, 0, 0};
    tbl[5]  = '{0, 32'd0,    2'd2, 32'd0,      1, 0, 32'h0,  1, 32'h10, 4'hC, 32'h12341234, 1, 0, 0};
    tbl[6]  = '{0, 32'd0,    2'd2, 32'd0,      1, 0, 32'h0,  0, 32'h0,  4'h0, 32'h0,        0, 0, 0};
    tbl[7]  = '{1, 32'h6,    2'd2, 32'd1,      1, 0, 32'h0,  0, 32'h0,  4'h0, 32'h0,        0, 1, 0};
    tbl[8]  = '{1, 32'h0,    2'd3, 32'd1,      1, 0, 32'h0,  0, 32'h0,  4'h0, 32'h0,        0, 1, 0};
    tbl[9]  = '{0, 32'd0,    2'd2, 32'd0,      1, 0, 32'h0,  0, 32'h0,  4'h0, 32'h0,        0, 0, 0};
    tbl[10] = '{1, 32'h10,   2'd2, 32'd5,      0, 1, 32'h13, 0, 32'h0,  4'h0, 32'h0,        1, 0, 1};
    tbl[11] = '{0, 32'd0,    2'd2, 32'd0,      0, 1, 32'h14, 1, 32'h10, 4'hF, 32'd5,        1, 0, 0};
    tbl[12] = '{0, 32'd0,    2'd2, 32'd0,      0, 1, 32'h13, 1, 32'h10, 4'hF, 32'd5,        1, 0, 1};
    tbl[13] = '{0, 32'd0,    2'd2, 32'd0,      1, 1, 32'h13, 0, 32'h0,  4'h0, 32'h0,        0, 0, 0};
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

    // Reset state
    #1;
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wd", mem_wd, 0);
    check("rst_be", mem_be, 0);
    check("rst_err", st_err, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_ready", st_ready, 0);
    check("rst_hazard", ld_hazard, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      set_st(tbl[i].sv, tbl[i].sa, tbl[i].ss, tbl[i].sd);
      mem_ack  = tbl[i].ack;
      ld_valid = tbl[i].lv;
      ld_addr  = tbl[i].la;
      tick();
      check($sformatf("v%0d_we", i), mem_we, tbl[i].we);
      check($sformatf("v%0d_count", i), count, tbl[i].cnt);
      check($sformatf("v%0d_err", i), st_err, tbl[i].err);
      check($sformatf("v%0d_hazard", i), ld_hazard, tbl[i].hz);
      if (tbl[i].we) begin
        check($sformatf("v%0d_addr", i), mem_addr, tbl[i].ma);
        check($sformatf("v%0d_be", i), mem_be, tbl[i].be);
        check($sformatf("v%0d_wd", i), mem_wd, tbl[i].wd);
      end
    end
    set_st(0, 0, 2'd2, 0);
    ld_valid = 1'b0;
    tick();

    // Fill to full with memory stalled, then drain in order
    mem_ack = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      if (idx < 5) set_st(1, addrs[idx], 2'd2, 32'h100 + idx);
      else set_st(0, 0, 2'd2, 0);
      rdy = st_ready;
      tick();
      if (rdy && st_valid) idx++;
    end
    check("full_accepted", idx, 4);
    check("full_count", count, 4);
    check("full_ready", st_ready, 0);
    mem_ack = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (idx < 5) set_st(1, addrs[idx], 2'd2, 32'h100 + idx);
      else set_st(0, 0, 2'd2, 0);
      if (mem_we && mem_ack) seen.push_back(mem_addr);
      rdy = st_ready;
      tick();
      if (rdy && st_valid) idx++;
    end
    check("drain_n", seen.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < seen.size()) check($sformatf("drain_order%0d", i), seen[i], addrs[i]);
    end

    // Asynchronous reset in the middle of a write
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_st(1, 32'h20 + 32'(4 * i), 2'd2, 32'h55 + i);
      tick();
    end
    set_st(0, 0, 2'd2, 0);
    tick();
    check("pre_rst_we", mem_we, 1);
    check("pre_rst_count", count, 3);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check("arst_we", mem_we, 0);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_ready", st_ready, 0);
    tick();
    reset   = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_we", mem_we, 0);
      check("post_rst_ready", st_ready, 1);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      st_addr  = 32'($urandom_range(0, 63));
      st_data  = $urandom;
      mem_ack  = ($urandom_range(0, 3) != 0);
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 32'($urandom_range(0, 63));
      tick();
    end
    set_st(0, 0, 2'd2, 0);
    mem_ack = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    check("final_empty", empty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
